vic_arbiter: RTL



---
 rtl/vic_arbiter_if.sv | 35 +++
 rtl/vic_arbiter.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/vic_arbiter_if.sv
// Bundles the device-side request/vector/ack lines and the processor-side
// virq/istb/ivec/iack handshake of the vectored-interrupt arbiter.
interface vic_arbiter_if #(
  parameter int NIRQ = 4
);
  logic [NIRQ-1:0]      irq_req;
  logic [16*NIRQ-1:0]   irq_vec;
  logic [NIRQ-1:0]      irq_ack;
  logic                 virq;
  logic                 istb;
  logic [15:0]          ivec;
  logic                 iack;

  // Arbiter view
  modport slave (
    input  irq_req,
    input  irq_vec,
    input  istb,
    output irq_ack,
    output virq,
    output ivec,
    output iack
  );

  // Environment view (devices plus processor)
  modport master (
    output irq_req,
    output irq_vec,
    output istb,
    input  irq_ack,
    input  virq,
    input  ivec,
    input  iack
  );
endinterface

// File: rtl/vic_arbiter.sv
// Vectored-interrupt arbiter: level requests in, virq/istb/ivec/iack handshake out.
// Optional macro VIC_PRIO_ROTATE_EN selects round-robin priority instead of fixed.
module vic_arbiter #(
  parameter int          NIRQ     = 4,
  parameter logic [15:0] SPUR_VEC = 16'o0
) (
  input  logic          clk_p,
  input  logic          rst,
  vic_arbiter_if.slave  bus
);

  localparam int IW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    GUARD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              virq_q, virq_d;
  logic              iack_q, iack_d;
  logic [15:0]       ivec_q, ivec_d;
  logic [NIRQ-1:0]   irq_ack_q, irq_ack_d;

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [15:0]       win_vec;

  logic [15:0]       vec_arr [NIRQ];

  generate
    for (genvar gi = 0; gi < NIRQ; gi++) begin : g_vec
      assign vec_arr[gi] = bus.irq_vec[16*gi +: 16];
    end
  endgenerate

`ifdef VIC_PRIO_ROTATE_EN
  logic [IW-1:0] rp_q, rp_d;
  logic [IW:0]   cand_sum;
  logic [IW-1:0] cand;

  // Walk the offsets from farthest to nearest so the source closest to rp wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_vec   = '0;
    cand_sum  = '0;
    cand      = '0;
    for (int off = NIRQ - 1; off >= 0; off--) begin
      cand_sum = {1'b0, rp_q} + (IW+1)'(off);
      if (cand_sum >= (IW+1)'(NIRQ)) begin
        cand_sum = cand_sum - (IW+1)'(NIRQ);
      end
      cand = cand_sum[IW-1:0];
      if (bus.irq_req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
        win_vec   = vec_arr[cand];
      end
    end
  end
`else
  // Descending scan: the lowest requesting index is the last assignment.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_vec   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (bus.irq_req[i]) begin
        win_found = 1'b1;
        win_idx   = IW'(i);
        win_vec   = vec_arr[i];
      end
    end
  end
`endif

  always_comb begin
    state_d   = state_q;
    virq_d    = virq_q;
    iack_d    = iack_q;
    ivec_d    = ivec_q;
    irq_ack_d = '0;
`ifdef VIC_PRIO_ROTATE_EN
    rp_d      = rp_q;
`endif
    case (state_q)
      IDLE: begin
        virq_d = |bus.irq_req;
        if (bus.istb) begin
          iack_d  = 1'b1;
          virq_d  = 1'b0;
          state_d = ACK;
          if (win_found) begin
            ivec_d    = win_vec & 16'hFFFC;
            irq_ack_d = NIRQ'(1) << win_idx;
`ifdef VIC_PRIO_ROTATE_EN
            rp_d = (win_idx == IW'(NIRQ - 1)) ? '0 : win_idx + 1'b1;
`endif
          end else begin
            // Passive release: nobody asked, hand back the spurious vector.
            ivec_d = SPUR_VEC;
          end
        end
      end
      ACK: begin
        virq_d = 1'b0;
        if (!bus.istb) begin
          iack_d  = 1'b0;
          ivec_d  = '0;
          state_d = GUARD;
        end
      end
      GUARD: begin
        // One dead cycle so the serviced device can drop its level request.
        virq_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        virq_d  = 1'b0;
        iack_d  = 1'b0;
        ivec_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_p) begin
    if (rst) begin
      state_q   <= IDLE;
      virq_q    <= 1'b0;
      iack_q    <= 1'b0;
      ivec_q    <= '0;
      irq_ack_q <= '0;
`ifdef VIC_PRIO_ROTATE_EN
      rp_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      virq_q    <= virq_d;
      iack_q    <= iack_d;
      ivec_q    <= ivec_d;
      irq_ack_q <= irq_ack_d;
`ifdef VIC_PRIO_ROTATE_EN
      rp_q      <= rp_d;
`endif
    end
  end

  assign bus.virq    = virq_q;
  assign bus.iack    = iack_q;
  assign bus.ivec    = ivec_q;
  assign bus.irq_ack = irq_ack_q;

endmodule
